ble_link_controller: RTL and testbench

BLE_LINK_CONTROLLER -- requirements
Module: ble_link_controller

---
 rtl/ble_link_controller.sv | 178 +++++++++++++++++
 tb/tb_ble_link_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ble_link_controller.sv
// BLE link controller: sleep / setup / advertise / connect sequencing plus a two-byte error report.
// Optional macro BLE_LINK_RETRY_EN adds bounded fast retries of a failed setup.
module ble_link_controller #(
    parameter int         SLP_W     = 24,
    parameter int         ADV_W     = 24,
    parameter int         MAX_RETRY = 3,
    parameter logic [7:0] ERR_HDR   = 8'hEE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SLP_W-1:0] slp_time_count,
    input  logic [ADV_W-1:0] adv_time_count,
    input  logic             programming,
    input  logic             direct_conn,
    input  logic             setup_done,
    input  logic             fail,
    input  logic             connect,
    input  logic             disconnect,
    input  logic             error_pulse,
    input  logic             tx_full,
    input  logic [1:0]       error_code,
    output logic             setting_up,
    output logic             en_cmd_mem_wr,
    output logic             tx_valid,
    output logic             mux_tx_setup,
    output logic             mux_transceiver,
    output logic             retry_exhausted,
    output logic [1:0]       mux_rx_setup,
    output logic [7:0]       tx_data,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ADV   = 3'd2,
        S_CONN  = 3'd3,
        S_PROG  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t           state;
    logic [SLP_W-1:0] slp_cnt;
    logic [ADV_W-1:0] adv_cnt;
    logic             byte_idx;
    logic [1:0]       err_code_q;
    logic             fast_wake;
    logic             wake;
    logic             adv_timeout;

`ifdef BLE_LINK_RETRY_EN
    logic [3:0] retry_cnt;
    logic [3:0] retry_next;
    logic       retry_exh_q;

    assign retry_next      = retry_cnt + 4'd1;
    assign retry_exhausted = retry_exh_q;
`else
    assign retry_exhausted = 1'b0;
`endif

    // fast_wake turns the next IDLE visit into a single-cycle pass-through.
    assign wake        = fast_wake || (slp_cnt == slp_time_count);
    assign adv_timeout = (adv_time_count != '0) && (adv_cnt == adv_time_count);
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            slp_cnt    <= '0;
            adv_cnt    <= '0;
            byte_idx   <= 1'b0;
            err_code_q <= 2'd0;
            fast_wake  <= 1'b0;
`ifdef BLE_LINK_RETRY_EN
            retry_cnt   <= 4'd0;
            retry_exh_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (slp_cnt != '1) slp_cnt <= slp_cnt + 1'b1;
                    if (direct_conn || wake) fast_wake <= 1'b0;
                    if (direct_conn)     state <= S_CONN;
                    else if (wake)       state <= programming ? S_PROG : S_SETUP;
                end
                S_SETUP: begin
                    if (fail) begin
                        state   <= S_IDLE;
                        slp_cnt <= '0;
`ifdef BLE_LINK_RETRY_EN
                        if (retry_next < 4'(MAX_RETRY)) begin
                            retry_cnt <= retry_next;
                            fast_wake <= 1'b1;
                        end else begin
                            retry_cnt   <= 4'd0;
                            retry_exh_q <= 1'b1;
                        end
`endif
                    end else if (setup_done) begin
                        state   <= S_ADV;
                        adv_cnt <= '0;
`ifdef BLE_LINK_RETRY_EN
                        retry_cnt   <= 4'd0;
                        retry_exh_q <= 1'b0;
`endif
                    end
                end
                S_ADV: begin
                    if (adv_cnt != '1) adv_cnt <= adv_cnt + 1'b1;
                    if (connect) begin
                        state <= S_CONN;
                    end else if (adv_timeout) begin
                        state   <= S_IDLE;
                        slp_cnt <= '0;
                    end
                end
                S_CONN: begin
                    if (disconnect && !direct_conn) begin
                        state   <= S_IDLE;
                        slp_cnt <= '0;
                    end
                end
                S_PROG: begin
                    if (!programming) begin
                        state   <= S_IDLE;
                        slp_cnt <= '0;
                    end else if (error_pulse) begin
                        state      <= S_ERR;
                        err_code_q <= error_code;
                        byte_idx   <= 1'b0;
                    end
                end
                // Byte handshake: a byte transfers on every cycle with tx_valid high
                // (tx_valid = !tx_full); there is no separate ready signal.
                S_ERR: begin
                    if (!tx_full) begin
                        if (byte_idx) begin
                            byte_idx <= 1'b0;
                            state    <= S_PROG;
                        end else begin
                            byte_idx <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        setting_up      = 1'b0;
        en_cmd_mem_wr   = 1'b0;
        tx_valid        = 1'b0;
        mux_tx_setup    = 1'b0;
        mux_transceiver = 1'b0;
        mux_rx_setup    = 2'd0;
        tx_data         = 8'h00;
        case (state)
            S_SETUP: setting_up = 1'b1;
            S_ADV:   mux_rx_setup = 2'd2;
            S_CONN:  mux_transceiver = 1'b1;
            S_PROG: begin
                mux_tx_setup  = 1'b1;
                mux_rx_setup  = 2'd1;
                en_cmd_mem_wr = 1'b1;
            end
            S_ERR: begin
                mux_tx_setup = 1'b1;
                mux_rx_setup = 2'd1;
                tx_valid     = !tx_full;
                tx_data      = byte_idx ? {6'b0, err_code_q} : ERR_HDR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ble_link_controller.sv
// Directed bench for ble_link_controller; expectations adapt to BLE_LINK_RETRY_EN.
module tb_ble_link_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] slp_time_count;
    logic [23:0] adv_time_count;
    logic        programming, direct_conn, setup_done, fail, connect, disconnect, error_pulse, tx_full;
    logic [1:0]  error_code;
    logic        setting_up, en_cmd_mem_wr, tx_valid, mux_tx_setup, mux_transceiver, retry_exhausted;
    logic [1:0]  mux_rx_setup;
    logic [7:0]  tx_data;
    logic [2:0]  state_dbg;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_SETUP = 3'd1, ST_ADV = 3'd2,
                           ST_CONN = 3'd3, ST_PROG = 3'd4, ST_ERR = 3'd5;

    int n_checks = 0;
    int n_fail   = 0;

    ble_link_controller dut (
        .clk(clk), .rst(rst),
        .slp_time_count(slp_time_count), .adv_time_count(adv_time_count),
        .programming(programming), .direct_conn(direct_conn), .setup_done(setup_done),
        .fail(fail), .connect(connect), .disconnect(disconnect),
        .error_pulse(error_pulse), .tx_full(tx_full), .error_code(error_code),
        .setting_up(setting_up), .en_cmd_mem_wr(en_cmd_mem_wr), .tx_valid(tx_valid),
        .mux_tx_setup(mux_tx_setup), .mux_transceiver(mux_transceiver),
        .retry_exhausted(retry_exhausted), .mux_rx_setup(mux_rx_setup),
        .tx_data(tx_data), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {setting_up, en_cmd_mem_wr, tx_valid, mux_tx_setup, mux_transceiver,
                retry_exhausted, mux_rx_setup, tx_data};
    endfunction

    initial begin
        rst = 1'b1;
        slp_time_count = 24'd5;
        adv_time_count = 24'd10;
        {programming, direct_conn, setup_done, fail, connect, disconnect, error_pulse, tx_full} = '0;
        error_code = 2'd0;
        tick();
        tick();
        check("reset_state", state_dbg, ST_IDLE);
        check("reset_outs", all_outs(), 16'h0000);

        // sleep dwell of 5: SETUP on the 6th edge after release
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("dwell_idle", setting_up, 1'b0);
        end
        tick();
        check("dwell_wake", setting_up, 1'b1);

        // setup failure handling
        fail = 1'b1;
        tick();
        fail = 1'b0;
        check("fail1_idle", state_dbg, ST_IDLE);
`ifdef BLE_LINK_RETRY_EN
        tick();
        check("fast_reentry1", setting_up, 1'b1);
        fail = 1'b1;
        tick();
        fail = 1'b0;
        check("fail2_idle", state_dbg, ST_IDLE);
        tick();
        check("fast_reentry2", setting_up, 1'b1);
        fail = 1'b1;
        tick();
        fail = 1'b0;
        check("fail3_idle", state_dbg, ST_IDLE);
        check("exhausted_set", retry_exhausted, 1'b1);
`endif
        repeat (5) tick();
        check("full_dwell_idle", state_dbg, ST_IDLE);
        tick();
        check("full_dwell_wake", setting_up, 1'b1);
`ifdef BLE_LINK_RETRY_EN
        check("exhausted_sticky", retry_exhausted, 1'b1);
`else
        check("exhausted_tied", retry_exhausted, 1'b0);
`endif

        // fail beats setup_done; zero dwell wakes on the first IDLE cycle
        slp_time_count = 24'd0;
        fail = 1'b1;
        setup_done = 1'b1;
        tick();
        fail = 1'b0;
        setup_done = 1'b0;
        check("fail_priority", state_dbg, ST_IDLE);
        tick();
        check("zero_dwell", setting_up, 1'b1);
        setup_done = 1'b1;
        tick();
        setup_done = 1'b0;
        check("adv_mux", mux_rx_setup, 2'd2);
        check("exhausted_clear", retry_exhausted, 1'b0);

        // advertisement timeout of 10 cycles
        repeat (10) tick();
        check("adv_hold", state_dbg, ST_ADV);
        tick();
        check("adv_timeout", state_dbg, ST_IDLE);
        tick();
        check("resetup", setting_up, 1'b1);
        setup_done = 1'b1;
        tick();
        setup_done = 1'b0;
        repeat (10) tick();
        connect = 1'b1;
        tick();
        connect = 1'b0;
        check("connect_wins_state", state_dbg, ST_CONN);
        check("connect_wins_mux", mux_transceiver, 1'b1);

        // disconnect and direct connection
        disconnect = 1'b1;
        tick();
        disconnect = 1'b0;
        check("disconnect", state_dbg, ST_IDLE);
        direct_conn = 1'b1;
        tick();
        check("direct_conn", mux_transceiver, 1'b1);
        disconnect = 1'b1;
        tick();
        tick();
        check("disc_ignored", state_dbg, ST_CONN);
        direct_conn = 1'b0;
        tick();
        disconnect = 1'b0;
        check("direct_drop", state_dbg, ST_IDLE);

        // programming with a stalled error report
        programming = 1'b1;
        tick();
        check("prog_outs", all_outs(), {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00});
        error_pulse = 1'b1;
        error_code  = 2'd2;
        tx_full     = 1'b1;
        tick();
        error_pulse = 1'b0;
        error_code  = 2'd1;
        programming = 1'b0;
        check("err_stall_outs", all_outs(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'hEE});
        tick();
        tick();
        check("err_stall_hold", state_dbg, ST_ERR);
        tx_full = 1'b0;
        #1;
        check("byte0_valid", tx_valid, 1'b1);
        check("byte0_data", tx_data, 8'hEE);
        tick();
        check("byte1_valid", tx_valid, 1'b1);
        check("byte1_data", tx_data, 8'h02);
        error_pulse = 1'b1;
        tick();
        check("back_to_prog", en_cmd_mem_wr, 1'b1);
        check("back_tx_valid", tx_valid, 1'b0);
        tick();
        error_pulse = 1'b0;
        check("prog_exit_priority", state_dbg, ST_IDLE);

        // reset aborts an error report after byte0
        programming = 1'b1;
        tick();
        check("prog_again", state_dbg, ST_PROG);
        error_pulse = 1'b1;
        error_code  = 2'd3;
        tick();
        error_pulse = 1'b0;
        check("abort_byte0", tx_data, 8'hEE);
        tick();
        check("abort_byte1_pending", tx_data, 8'h03);
        rst = 1'b1;
        tick();
        check("abort_state", state_dbg, ST_IDLE);
        check("abort_outs", all_outs(), 16'h0000);
        rst = 1'b0;
        programming = 1'b0;

        // no timeout when adv_time_count is zero
        adv_time_count = 24'd0;
        tick();
        setup_done = 1'b1;
        tick();
        setup_done = 1'b0;
        repeat (20) tick();
        check("adv_no_timeout", state_dbg, ST_ADV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
